// File: rtl/iob_eth_rx_ctrl_pkg.sv
// Shared encodings and byte-lane helpers for the iob_eth RX sequencer.
package iob_eth_rx_ctrl_pkg;

    // Sequencer FSM states
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StTxPoll = 3'd1;
    localparam logic [2:0] StCfg    = 3'd2;
    localparam logic [2:0] StRxPoll = 3'd3;
    localparam logic [2:0] StRd     = 3'd4;
    localparam logic [2:0] StPush   = 3'd5;
    localparam logic [2:0] StAck    = 3'd6;

    // Bus master states
    localparam logic [1:0] MIdle = 2'd0;
    localparam logic [1:0] MReq  = 2'd1;
    localparam logic [1:0] MResp = 2'd2;

    // STATUS register bits
    localparam int unsigned TxRdyBit = 0;
    localparam int unsigned RxRdyBit = 1;

    // Contiguous strobe mask for an access of 'size' bytes starting at lane 0
    function automatic logic [3:0] size_strb(input logic [2:0] size);
        case (size)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Move lane-0 data up to byte lane 'off'
    function automatic logic [31:0] lane_shl(input logic [31:0] d, input logic [1:0] off);
        return d << {off, 3'b000};
    endfunction

    function automatic logic [3:0] strb_shl(input logic [3:0] s, input logic [1:0] off);
        return s << off;
    endfunction

    // Pick the byte sitting in lane 'off'
    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] off);
        return 8'(d >> {off, 3'b000});
    endfunction

endpackage

// File: rtl/iob_eth_bus_master.sv
// Single-outstanding IOb request engine: latches a request, holds it until
// accepted, then presents the lane-aligned read byte with a one-cycle done.
module iob_eth_bus_master
    import iob_eth_rx_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        size,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              eth_valid,
    output logic [ADDR_W-1:0] eth_address,
    output logic [31:0]       eth_wdata,
    output logic [3:0]        eth_wstrb,
    input  logic [31:0]       eth_rdata,
    input  logic              eth_ready
);

    logic [1:0]        mst_q, mst_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    // Request state and held request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_q   <= MIdle;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            mst_q   <= mst_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Accept a new request only when idle; the response cycle keeps valid low
    // so back-to-back requests always see a one-cycle gap.
    always_comb begin
        mst_d   = mst_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (mst_q)
            MIdle: begin
                if (start) begin
                    valid_d = 1'b1;
                    addr_d  = addr;
                    wdata_d = lane_shl(wdata, addr[1:0]);
                    wstrb_d = write ? strb_shl(size_strb(size), addr[1:0]) : 4'b0000;
                    mst_d   = MReq;
                end
            end
            MReq: begin
                if (eth_ready) begin
                    valid_d = 1'b0;
                    mst_d   = MResp;
                end
            end
            MResp:   mst_d = MIdle;
            default: mst_d = MIdle;
        endcase
    end

    assign done        = (mst_q == MResp);
    assign rdata       = lane_byte(eth_rdata, addr_q[1:0]);
    assign eth_valid   = valid_q;
    assign eth_address = addr_q;
    assign eth_wdata   = wdata_q;
    assign eth_wstrb   = wstrb_q;

endmodule

// File: rtl/iob_eth_rx_ctrl.sv
// Hardware replacement for the iob_eth RX driver loop: configures TX, polls
// for frames, streams each RX byte out and acknowledges the frame.
module iob_eth_rx_ctrl
    import iob_eth_rx_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned STATUS_ADDR    = 12'h000,
    parameter int unsigned TX_NBYTES_ADDR = 12'h004,
    parameter int unsigned RCVACK_ADDR    = 12'h008,
    parameter int unsigned DATA_RD_ADDR   = 12'h800,
    parameter int unsigned NBYTES_W       = 11,
    parameter int unsigned POLL_MAX       = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NBYTES_W-1:0] nbytes,
    output logic                eth_valid,
    output logic [ADDR_W-1:0]   eth_address,
    output logic [31:0]         eth_wdata,
    output logic [3:0]          eth_wstrb,
    input  logic [31:0]         eth_rdata,
    input  logic                eth_ready,
    output logic [7:0]          m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic                timeout
);

    localparam int unsigned PollW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

    logic [2:0]          state_q, state_d;
    logic [NBYTES_W-1:0] nbytes_q, nbytes_d;
    logic [NBYTES_W-1:0] idx_q, idx_d;
    logic [7:0]          byte_q, byte_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                timeout_q, timeout_d;
    logic                en_q;
    logic [PollW-1:0]    poll_cnt_q, poll_cnt_d;

    logic              bus_start, bus_write, bus_done;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [2:0]        bus_size;
    logic [7:0]        bus_rdata;
    logic              poll_hit;

    iob_eth_bus_master #(
        .ADDR_W(ADDR_W)
    ) u_bus (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (bus_start),
        .write      (bus_write),
        .addr       (bus_addr),
        .wdata      (bus_wdata),
        .size       (bus_size),
        .done       (bus_done),
        .rdata      (bus_rdata),
        .eth_valid  (eth_valid),
        .eth_address(eth_address),
        .eth_wdata  (eth_wdata),
        .eth_wstrb  (eth_wstrb),
        .eth_rdata  (eth_rdata),
        .eth_ready  (eth_ready)
    );

    // Sequencer state, frame bookkeeping and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            nbytes_q    <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            frame_cnt_q <= '0;
            timeout_q   <= 1'b0;
            en_q        <= 1'b0;
            poll_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            nbytes_q    <= nbytes_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            frame_cnt_q <= frame_cnt_d;
            timeout_q   <= timeout_d;
            en_q        <= en;
            poll_cnt_q  <= poll_cnt_d;
        end
    end

    // Bus request issued by each bus-owning state
    always_comb begin
        bus_start = 1'b0;
        bus_write = 1'b0;
        bus_addr  = ADDR_W'(STATUS_ADDR);
        bus_wdata = '0;
        bus_size  = 3'd0;
        case (state_q)
            StTxPoll, StRxPoll: bus_start = 1'b1;
            StCfg: begin
                bus_start = 1'b1;
                bus_write = 1'b1;
                bus_addr  = ADDR_W'(TX_NBYTES_ADDR);
                bus_wdata = 32'(nbytes_q);
                bus_size  = 3'd2;
            end
            StRd: begin
                bus_start = 1'b1;
                bus_addr  = ADDR_W'(DATA_RD_ADDR) + ADDR_W'(idx_q);
            end
            StAck: begin
                bus_start = 1'b1;
                bus_write = 1'b1;
                bus_addr  = ADDR_W'(RCVACK_ADDR);
                bus_wdata = 32'd1;
                bus_size  = 3'd1;
            end
            default: ;
        endcase
    end

    assign poll_hit = (POLL_MAX != 0) && ((32'(poll_cnt_q) + 32'd1) == POLL_MAX);

    // Next-state logic; decisions are taken only on bus completion so an issued
    // request is never abandoned.
    always_comb begin
        state_d     = state_q;
        nbytes_d    = nbytes_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        frame_cnt_d = frame_cnt_q;
        timeout_d   = timeout_q;
        poll_cnt_d  = poll_cnt_q;
        if (en && !en_q) timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                // A pending timeout blocks restart until en is re-pulsed
                if (en && !timeout_q) begin
                    nbytes_d = nbytes;
                    state_d  = StTxPoll;
                end
            end
            StTxPoll, StRxPoll: begin
                if (bus_done) begin
                    poll_cnt_d = poll_cnt_q + PollW'(1);
                    if (!en) begin
                        state_d = StIdle;
                    end else if (state_q == StTxPoll && bus_rdata[TxRdyBit]) begin
                        state_d = StCfg;
                    end else if (state_q == StRxPoll && bus_rdata[RxRdyBit]) begin
                        idx_d   = '0;
                        state_d = (nbytes_q == '0) ? StAck : StRd;
                    end else if (poll_hit) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StCfg: if (bus_done) state_d = StRxPoll;
            StRd: begin
                if (bus_done) begin
                    byte_d  = bus_rdata;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (m_ready) begin
                    idx_d   = idx_q + NBYTES_W'(1);
                    state_d = (idx_q == nbytes_q - NBYTES_W'(1)) ? StAck : StRd;
                end
            end
            StAck: begin
                if (bus_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = en ? StRxPoll : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) poll_cnt_d = '0;
    end

    assign m_data    = byte_q;
    assign m_valid   = (state_q == StPush);
    assign busy      = (state_q != StIdle);
    assign frame_cnt = frame_cnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_iob_eth_rx_ctrl.sv
// Scoreboard bench: expected bus requests and stream bytes are queued up front,
// a negedge monitor compares against what the DUT actually presents.
module tb_iob_eth_rx_ctrl;

    localparam logic [11:0] StatusA = 12'h000;
    localparam logic [11:0] TxA     = 12'h004;
    localparam logic [11:0] RcvA    = 12'h008;
    localparam logic [11:0] DataA   = 12'h800;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [10:0] nbytes = 11'd46;
    logic        eth_valid, eth_ready = 1'b0;
    logic [11:0] eth_address;
    logic [31:0] eth_wdata, eth_rdata = 32'h0;
    logic [3:0]  eth_wstrb;
    logic [7:0]  m_data;
    logic        m_valid, m_ready = 1'b1;
    logic        busy, timeout;
    logic [15:0] frame_cnt;

    // Second instance with a short poll limit for the timeout path
    logic        en2 = 1'b0;
    logic        eth_valid2;
    logic [11:0] eth_address2;
    logic [31:0] eth_wdata2;
    logic [3:0]  eth_wstrb2;
    logic [7:0]  m_data2;
    logic        m_valid2, busy2, timeout2;
    logic [15:0] frame_cnt2;

    int total = 0;
    int bad = 0;

    txn_t        exp_bus[$];
    logic [7:0]  exp_byte[$];
    int          bytes_seen = 0;
    int          st_reads = 0;
    int          model_frames = 0;
    int          n2 = 0;
    int          cyc = 0;
    logic        stall = 1'b0, slow = 1'b0, rand_mr = 1'b0, chk_en = 1'b1;
    logic        hold_pend = 1'b0, acc_prev = 1'b0, m_hold = 1'b0;
    logic [11:0] held_addr;
    logic [31:0] held_wdata;
    logic [3:0]  held_wstrb;
    logic [7:0]  held_byte;

    always #5 clk = ~clk;

    iob_eth_rx_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .nbytes     (nbytes),
        .eth_valid  (eth_valid),
        .eth_address(eth_address),
        .eth_wdata  (eth_wdata),
        .eth_wstrb  (eth_wstrb),
        .eth_rdata  (eth_rdata),
        .eth_ready  (eth_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .timeout    (timeout)
    );

    iob_eth_rx_ctrl #(
        .POLL_MAX(8)
    ) dut_to (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en2),
        .nbytes     (11'd5),
        .eth_valid  (eth_valid2),
        .eth_address(eth_address2),
        .eth_wdata  (eth_wdata2),
        .eth_wstrb  (eth_wstrb2),
        .eth_rdata  (32'h0000_0001),
        .eth_ready  (1'b1),
        .m_data     (m_data2),
        .m_valid    (m_valid2),
        .m_ready    (1'b1),
        .busy       (busy2),
        .frame_cnt  (frame_cnt2),
        .timeout    (timeout2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_rd(input logic [11:0] a);
        txn_t t;
        t.addr = a; t.wdata = 32'h0; t.wstrb = 4'b0000;
        exp_bus.push_back(t);
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.addr = a; t.wdata = d; t.wstrb = s;
        exp_bus.push_back(t);
    endtask

    // Bus/stream monitor and iob_eth model for the main instance
    always @(negedge clk) begin
        txn_t       e;
        logic [7:0] b;
        int         k;
        cyc++;
        if (chk_en && rst_n) begin
            if (hold_pend) begin
                check("bus_hold_valid", 32'(eth_valid), 32'd1);
                check("bus_hold_addr", 32'(eth_address), 32'(held_addr));
                check("bus_hold_wdata", eth_wdata, held_wdata);
                check("bus_hold_wstrb", 32'(eth_wstrb), 32'(held_wstrb));
            end
            if (acc_prev) check("bus_gap", 32'(eth_valid), 32'd0);
            if (m_hold) begin
                check("m_hold_valid", 32'(m_valid), 32'd1);
                check("m_hold_data", 32'(m_data), 32'(held_byte));
            end
        end
        eth_ready = !stall && !(slow && (cyc % 3 == 0));
        m_ready   = rand_mr ? ($urandom_range(0, 99) >= 30) : 1'b1;
        acc_prev  = eth_valid && eth_ready;
        hold_pend = eth_valid && !eth_ready;
        held_addr = eth_address; held_wdata = eth_wdata; held_wstrb = eth_wstrb;
        if (acc_prev) begin
            if (exp_bus.size() == 0) begin
                total++; bad++;
                $display("FAIL bus_unexpected: got addr %0h wstrb %0h, no request expected",
                         eth_address, eth_wstrb);
            end else begin
                e = exp_bus.pop_front();
                check("bus_addr", 32'(eth_address), 32'(e.addr));
                check("bus_wstrb", 32'(eth_wstrb), 32'(e.wstrb));
                if (e.wstrb != 4'b0000) check("bus_wdata", eth_wdata, e.wdata);
            end
            if (eth_wstrb == 4'b0000) begin
                if (eth_address == StatusA) begin
                    eth_rdata = {30'b0, st_reads >= (model_frames == 0 ? 20 : 3), 1'b1};
                    st_reads++;
                end else begin
                    k = int'(eth_address) - int'(DataA);
                    b = 8'h0E + 8'(k);
                    eth_rdata = 32'hA5A5_A5A5;
                    eth_rdata[8*eth_address[1:0] +: 8] = b;
                end
            end else begin
                if (eth_address == TxA) st_reads = 0;
                if (eth_address == RcvA) begin
                    st_reads = 0;
                    model_frames++;
                end
            end
        end
        m_hold    = m_valid && !m_ready;
        held_byte = m_data;
        if (rst_n && m_valid && m_ready) begin
            bytes_seen++;
            if (exp_byte.size() == 0) begin
                total++; bad++;
                $display("FAIL byte_unexpected: got %0h, no byte expected", m_data);
            end else begin
                check("m_data", 32'(m_data), 32'(exp_byte.pop_front()));
            end
        end
    end

    // Transaction counter for the timeout instance (ready is tied high)
    always @(negedge clk) begin
        if (eth_valid2) begin
            n2++;
            if (n2 == 2) begin
                check("to_cfg_addr", 32'(eth_address2), 32'(TxA));
                check("to_cfg_wdata", eth_wdata2, 32'd5);
                check("to_cfg_wstrb", 32'(eth_wstrb2), 32'b0011);
            end
        end
        if (m_valid2) check("to_no_stream", 32'(m_valid2), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        // Frame 1: TX ready at once, RX after 20 polls, consumer always ready
        push_rd(StatusA);
        push_wr(TxA, 32'h0000_002E, 4'b0011);
        repeat (21) push_rd(StatusA);
        for (int k = 0; k < 46; k++) push_rd(DataA + 12'(k));
        push_wr(RcvA, 32'd1, 4'b0001);
        // Frame 2: RX after 3 polls, en dropped mid-frame
        repeat (4) push_rd(StatusA);
        for (int k = 0; k < 46; k++) push_rd(DataA + 12'(k));
        push_wr(RcvA, 32'd1, 4'b0001);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 46; k++) exp_byte.push_back(8'h0E + 8'(k));

        repeat (3) @(negedge clk);
        check("rst_eth_valid", 32'(eth_valid), 32'd0);
        check("rst_eth_wstrb", 32'(eth_wstrb), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        for (i = 0; i < 3000 && frame_cnt != 16'd1; i++) @(negedge clk);
        check("frame1_done", 32'(frame_cnt), 32'd1);
        check("frame1_bytes", 32'(bytes_seen), 32'd46);
        check("frame1_busy", 32'(busy), 32'd1);

        rand_mr = 1'b1;
        slow    = 1'b1;
        for (i = 0; i < 3000 && bytes_seen < 56; i++) @(negedge clk);
        check("frame2_at_byte10", 32'(bytes_seen), 32'd56);
        en = 1'b0;
        for (i = 0; i < 3000 && busy; i++) @(negedge clk);
        check("frame2_idle", 32'(busy), 32'd0);
        check("frame2_cnt", 32'(frame_cnt), 32'd2);
        check("frame2_bytes", 32'(bytes_seen), 32'd92);
        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("byte_queue_drained", 32'(exp_byte.size()), 32'd0);
        check("no_timeout", 32'(timeout), 32'd0);
        rand_mr = 1'b0;
        slow    = 1'b0;

        // Timeout path on the second instance
        en2 = 1'b1;
        for (i = 0; i < 500 && !timeout2; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        check("to_flag", 32'(timeout2), 32'd1);
        check("to_busy", 32'(busy2), 32'd0);
        check("to_txn_count", 32'(n2), 32'd10);
        check("to_frame_cnt", 32'(frame_cnt2), 32'd0);
        en2 = 1'b0;
        repeat (2) @(negedge clk);
        check("to_sticky", 32'(timeout2), 32'd1);
        en2 = 1'b1;
        repeat (2) @(negedge clk);
        check("to_cleared", 32'(timeout2), 32'd0);
        en2 = 1'b0;

        // Async reset while a request is stalled
        stall = 1'b1;
        en    = 1'b1;
        for (i = 0; i < 20 && !eth_valid; i++) @(negedge clk);
        check("stall_valid", 32'(eth_valid), 32'd1);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_eth_valid", 32'(eth_valid), 32'd0);
        check("async_m_valid", 32'(m_valid), 32'd0);
        check("async_frame_cnt", 32'(frame_cnt), 32'd0);
        check("async_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
